sys_ctrl_gen2: RTL and testbench

Parametrised successor system controller, instantiated once per subsystem next to the Cortex-M core in the FCLK domain.
- Provides N independent power-up request/acknowledge handshakes (debug, system, accelerator domains) with configurable synchroniser depth and acknowledge delay.
- Replaces the combinational lockup-reset path with a filtered, stretched, arbitrated system-reset request FSM that also accepts SYSRESETREQ.

---
 rtl/sys_ctrl_gen2_pkg.sv | 21 ++
 rtl/sys_ctrl_gen2_if.sv | 54 +++++
 rtl/sys_ctrl_pwrup_ch.sv | 43 ++++
 rtl/sys_ctrl_gen2.sv | 126 ++++++++++++
 tb/tb_sys_ctrl_gen2.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_ctrl_gen2_pkg.sv
// Shared types and constants for the sys_ctrl_gen2 system controller.
package sys_ctrl_gen2_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CAUSE_W  = 2;
  localparam int unsigned CAUSE_LK = 0;
  localparam int unsigned CAUSE_SW = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } rst_state_e;

  // Increment that sticks at lim once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sys_ctrl_gen2_if.sv
// Core-side signal bundle of sys_ctrl_gen2; cause outputs exist only with
// SYS_CTRL_GEN2_CAUSE_EN defined.
interface sys_ctrl_gen2_if
  import sys_ctrl_gen2_pkg::*;
#(
  parameter int unsigned NUM_PWR_CH = 2
);

  logic [NUM_PWR_CH-1:0] PWRUPREQ;
  logic [NUM_PWR_CH-1:0] PWRUPACK;
  logic                  LOCKUP;
  logic                  LOCKUP_RESET_EN;
  logic                  SYSRESETREQ;
  logic                  SYSRESETREQ_EN;
  logic                  SYSRST_OUT;
  logic                  RST_BUSY;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
  logic                  CAUSE_CLR;
  logic [CAUSE_W-1:0]    RST_CAUSE;
`endif

  // Core / power controller side
  modport master (
    output PWRUPREQ,
    output LOCKUP,
    output LOCKUP_RESET_EN,
    output SYSRESETREQ,
    output SYSRESETREQ_EN,
    input  PWRUPACK,
    input  SYSRST_OUT,
    input  RST_BUSY
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    , output CAUSE_CLR
    , input  RST_CAUSE
`endif
  );

  // System controller side
  modport slave (
    input  PWRUPREQ,
    input  LOCKUP,
    input  LOCKUP_RESET_EN,
    input  SYSRESETREQ,
    input  SYSRESETREQ_EN,
    output PWRUPACK,
    output SYSRST_OUT,
    output RST_BUSY
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    , input  CAUSE_CLR
    , output RST_CAUSE
`endif
  );

endinterface

// File: rtl/sys_ctrl_pwrup_ch.sv
// One power-up request/acknowledge channel: synchroniser, hold-off counter, ack.
module sys_ctrl_pwrup_ch
  import sys_ctrl_gen2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_DELAY   = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic ack_o
);

  localparam logic [CNT_W-1:0] DLY = CNT_W'(ACK_DELAY);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;

  // Ack is precomputed from next-state values so it equals sreq & (cnt==DLY)
  // of the registered terms while coming straight from a flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_i};
    cnt_d  = sync_q[SYNC_STAGES-1] ? sat_inc(cnt_q, DLY) : '0;
    ack_d  = sync_d[SYNC_STAGES-1] && (cnt_d == DLY);
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
    end
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/sys_ctrl_gen2.sv
// sys_ctrl_gen2: power-up handshakes plus filtered/stretched system-reset FSM.
// Optional reset-cause register enabled by defining SYS_CTRL_GEN2_CAUSE_EN.
module sys_ctrl_gen2
  import sys_ctrl_gen2_pkg::*;
#(
  parameter int unsigned NUM_PWR_CH       = 2,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned ACK_DELAY        = 0,
  parameter int unsigned LOCKUP_FILTER    = 4,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input logic               FCLK,
  input logic               PORESETn,
  sys_ctrl_gen2_if.slave    bus
);

  localparam logic [CNT_W-1:0] LK_LIM   = CNT_W'(LOCKUP_FILTER);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RST_PULSE_CYCLES - 1);

  logic [NUM_PWR_CH-1:0] ack_w;

  // Independent power-up channels
  for (genvar i = 0; i < NUM_PWR_CH; i++) begin : g_ch
    sys_ctrl_pwrup_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .ACK_DELAY   (ACK_DELAY)
    ) u_ch (
      .clk_i  (FCLK),
      .rst_ni (PORESETn),
      .req_i  (bus.PWRUPREQ[i]),
      .ack_o  (ack_w[i])
    );
  end

  assign bus.PWRUPACK = ack_w;

  logic             lk_term_c, sw_term_c, trig_lk_c, trig_sw_c;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             sw_prev_q;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             rst_q, rst_d;
  logic             busy_q, busy_d;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
  logic [CAUSE_W-1:0] cause_q, cause_d;
`endif

  // Trigger qualification: lockup filter and SYSRESETREQ edge detect
  always_comb begin
    lk_term_c = bus.LOCKUP & bus.LOCKUP_RESET_EN;
    sw_term_c = bus.SYSRESETREQ & bus.SYSRESETREQ_EN;
    lcnt_d    = lk_term_c ? sat_inc(lcnt_q, LK_LIM) : '0;
    // Fires only on the cycle the filter first saturates, so a held
    // lockup cannot re-arm until it drops.
    trig_lk_c = (lcnt_d == LK_LIM) && (lcnt_q != LK_LIM);
    trig_sw_c = sw_term_c & ~sw_prev_q;
  end

  // Reset FSM next state; outputs derived from next state so they register
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (trig_lk_c || trig_sw_c) begin
          state_d = ASSERT;
          pcnt_d  = PULSE_LD;
        end
      end
      ASSERT: begin
        if (pcnt_q == '0) state_d = HOLD;
        else              pcnt_d  = pcnt_q - CNT_W'(1);
      end
      HOLD: begin
        if (!bus.LOCKUP && !bus.SYSRESETREQ) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rst_d  = (state_d == ASSERT);
    busy_d = (state_d != IDLE);
  end

`ifdef SYS_CTRL_GEN2_CAUSE_EN
  // Sticky cause bits; a set on the same edge overrides a clear
  always_comb begin
    cause_d = cause_q;
    if (bus.CAUSE_CLR) cause_d = '0;
    if (state_q == IDLE) begin
      if (trig_lk_c) cause_d[CAUSE_LK] = 1'b1;
      if (trig_sw_c) cause_d[CAUSE_SW] = 1'b1;
    end
  end
`endif

  // Controller registers; async clear also aborts a pulse in flight
  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      lcnt_q    <= '0;
      sw_prev_q <= 1'b0;
      state_q   <= IDLE;
      pcnt_q    <= '0;
      rst_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
      cause_q   <= '0;
`endif
    end else begin
      lcnt_q    <= lcnt_d;
      sw_prev_q <= sw_term_c;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
      cause_q   <= cause_d;
`endif
    end
  end

  assign bus.SYSRST_OUT = rst_q;
  assign bus.RST_BUSY   = busy_q;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
  assign bus.RST_CAUSE  = cause_q;
`endif

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Scoreboard bench for sys_ctrl_gen2: default instance plus a
// SYNC_STAGES=3 / ACK_DELAY=5 instance for handshake timing.
module tb_sys_ctrl_gen2;

  logic FCLK = 1'b0;
  logic PORESETn;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 FCLK = ~FCLK;
  always @(posedge FCLK) cyc <= cyc + 1;

  sys_ctrl_gen2_if #(.NUM_PWR_CH(2)) bus_a ();
  sys_ctrl_gen2_if #(.NUM_PWR_CH(1)) bus_b ();

  sys_ctrl_gen2 #(
    .NUM_PWR_CH(2), .SYNC_STAGES(2), .ACK_DELAY(0),
    .LOCKUP_FILTER(4), .RST_PULSE_CYCLES(16)
  ) dut_a (
    .FCLK(FCLK), .PORESETn(PORESETn), .bus(bus_a.slave)
  );

  sys_ctrl_gen2 #(
    .NUM_PWR_CH(1), .SYNC_STAGES(3), .ACK_DELAY(5),
    .LOCKUP_FILTER(4), .RST_PULSE_CYCLES(16)
  ) dut_b (
    .FCLK(FCLK), .PORESETn(PORESETn), .bus(bus_b.slave)
  );

  typedef enum int {S_RST, S_BUSY, S_ACKA, S_ACKB, S_CAUSE} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] obs(input sig_e s);
    case (s)
      S_RST:   return {7'd0, bus_a.SYSRST_OUT};
      S_BUSY:  return {7'd0, bus_a.RST_BUSY};
      S_ACKA:  return {6'd0, bus_a.PWRUPACK};
      S_ACKB:  return {7'd0, bus_b.PWRUPACK};
`ifdef SYS_CTRL_GEN2_CAUSE_EN
      S_CAUSE: return {6'd0, bus_a.RST_CAUSE};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  // Push an expected value for the cycle dly edges from now
  task automatic expect_at(input string tag, input sig_e s, input int dly,
                           input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.cyc = cyc + dly;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge FCLK);
    #1;
  endtask

  // Pop and compare every entry that has come due
  always @(negedge FCLK) begin
    exp_t       e;
    logic [7:0] o;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        e = sb[i];
        o = obs(e.sig);
        n_tests++;
        assert (o === e.val) else begin
          n_fail++;
          $error("FAIL %s cyc=%0d: observed %0h expected %0h", e.tag, cyc, o, e.val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PORESETn              = 1'b0;
    bus_a.PWRUPREQ        = '0;
    bus_a.LOCKUP          = 1'b0;
    bus_a.LOCKUP_RESET_EN = 1'b0;
    bus_a.SYSRESETREQ     = 1'b0;
    bus_a.SYSRESETREQ_EN  = 1'b0;
    bus_b.PWRUPREQ        = '0;
    bus_b.LOCKUP          = 1'b0;
    bus_b.LOCKUP_RESET_EN = 1'b0;
    bus_b.SYSRESETREQ     = 1'b0;
    bus_b.SYSRESETREQ_EN  = 1'b0;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    bus_a.CAUSE_CLR = 1'b0;
    bus_b.CAUSE_CLR = 1'b0;
`endif

    // Reset values
    tick(2);
    n_tests++;
    if (bus_a.SYSRST_OUT !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_direct_sysrst: observed %b expected 0", bus_a.SYSRST_OUT);
    end
    n_tests++;
    if (bus_a.RST_BUSY !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_direct_busy: observed %b expected 0", bus_a.RST_BUSY);
    end
    n_tests++;
    if (bus_a.PWRUPACK !== 2'b00) begin
      n_fail++;
      $error("FAIL rst_direct_acka: observed %b expected 00", bus_a.PWRUPACK);
    end
    n_tests++;
    if (bus_b.PWRUPACK !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_direct_ackb: observed %b expected 0", bus_b.PWRUPACK);
    end
    expect_at("rst_sysrst", S_RST,  0, 8'd0);
    expect_at("rst_busy",   S_BUSY, 0, 8'd0);
    expect_at("rst_acka",   S_ACKA, 0, 8'd0);
    expect_at("rst_ackb",   S_ACKB, 0, 8'd0);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    expect_at("rst_cause",  S_CAUSE, 0, 8'd0);
`endif
    tick(1);
    PORESETn = 1'b1;
    tick(2);

    // Default channel: rise after 2 edges, fall after 2 edges, ch1 idle
    bus_a.PWRUPREQ = 2'b01;
    expect_at("acka_rise_m1", S_ACKA, 1, 8'd0);
    expect_at("acka_rise",    S_ACKA, 2, 8'd1);
    expect_at("acka_hold",    S_ACKA, 5, 8'd1);
    tick(6);
    n_tests++;
    if (bus_a.PWRUPACK !== 2'b01) begin
      n_fail++;
      $error("FAIL acka_direct: observed %b expected 01", bus_a.PWRUPACK);
    end
    bus_a.PWRUPREQ = 2'b00;
    expect_at("acka_fall_m1", S_ACKA, 1, 8'd1);
    expect_at("acka_fall",    S_ACKA, 2, 8'd0);
    tick(4);

    // 3-stage sync + 5-cycle delay: ack at edge 8, falls 3 edges after drop
    bus_b.PWRUPREQ = 1'b1;
    expect_at("ackb_rise_m1", S_ACKB, 7, 8'd0);
    expect_at("ackb_rise",    S_ACKB, 8, 8'd1);
    expect_at("ackb_hold",    S_ACKB, 10, 8'd1);
    tick(10);
    bus_b.PWRUPREQ = 1'b0;
    expect_at("ackb_fall_m1", S_ACKB, 2, 8'd1);
    expect_at("ackb_fall",    S_ACKB, 3, 8'd0);
    tick(5);

    // 4-cycle request pulse never reaches the delay
    bus_b.PWRUPREQ = 1'b1;
    expect_at("ackb_short6",  S_ACKB, 6, 8'd0);
    expect_at("ackb_short8",  S_ACKB, 8, 8'd0);
    expect_at("ackb_short10", S_ACKB, 10, 8'd0);
    tick(4);
    bus_b.PWRUPREQ = 1'b0;
    tick(8);

    // Lockup for 3 cycles is filtered out
    bus_a.LOCKUP_RESET_EN = 1'b1;
    bus_a.LOCKUP          = 1'b1;
    expect_at("lk3_rst4",  S_RST,  4, 8'd0);
    expect_at("lk3_busy4", S_BUSY, 4, 8'd0);
    expect_at("lk3_rst6",  S_RST,  6, 8'd0);
    tick(3);
    bus_a.LOCKUP = 1'b0;
    tick(5);

    // Lockup held: 16-cycle pulse, HOLD until lockup drops
    bus_a.LOCKUP = 1'b1;
    expect_at("lk_rst_pre",  S_RST,  3, 8'd0);
    expect_at("lk_rst_rise", S_RST,  4, 8'd1);
    expect_at("lk_busy",     S_BUSY, 4, 8'd1);
    expect_at("lk_rst_last", S_RST,  19, 8'd1);
    expect_at("lk_rst_fall", S_RST,  20, 8'd0);
    expect_at("lk_hold",     S_BUSY, 25, 8'd1);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    expect_at("lk_cause",    S_CAUSE, 4, 8'd1);
`endif
    tick(30);
    n_tests++;
    if (bus_a.RST_BUSY !== 1'b1) begin
      n_fail++;
      $error("FAIL lk_hold_direct: observed %b expected 1", bus_a.RST_BUSY);
    end
    bus_a.LOCKUP = 1'b0;
    expect_at("lk_hold_end", S_BUSY, 0, 8'd1);
    expect_at("lk_idle",     S_BUSY, 1, 8'd0);
    tick(3);

    // Lockup and SW triggers on the same edge: one pulse, both causes
    bus_a.SYSRESETREQ_EN = 1'b1;
    bus_a.LOCKUP         = 1'b1;
    tick(3);
    bus_a.SYSRESETREQ = 1'b1;
    expect_at("both_pre",  S_RST, 0, 8'd0);
    expect_at("both_rise", S_RST, 1, 8'd1);
    expect_at("both_last", S_RST, 16, 8'd1);
    expect_at("both_fall", S_RST, 17, 8'd0);
    expect_at("both_post", S_RST, 19, 8'd0);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    expect_at("both_cause", S_CAUSE, 1, 8'd3);
`endif
    tick(20);
    bus_a.LOCKUP      = 1'b0;
    bus_a.SYSRESETREQ = 1'b0;
    tick(2);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    // Cause survives the pulse; CAUSE_CLR clears on the next edge
    expect_at("cause_sticky", S_CAUSE, 0, 8'd3);
    bus_a.CAUSE_CLR = 1'b1;
    tick(1);
    bus_a.CAUSE_CLR = 1'b0;
    expect_at("cause_clr", S_CAUSE, 0, 8'd0);
    tick(1);
`endif

    // SW request re-pulsed and enable dropped mid-ASSERT: width unchanged
    bus_a.LOCKUP_RESET_EN = 1'b0;
    bus_a.SYSRESETREQ     = 1'b1;
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    bus_a.CAUSE_CLR = 1'b1;
    expect_at("sw_cause_setwins", S_CAUSE, 1, 8'd2);
`endif
    expect_at("sw_rise", S_RST,  1, 8'd1);
    expect_at("sw_last", S_RST,  16, 8'd1);
    expect_at("sw_fall", S_RST,  17, 8'd0);
    expect_at("sw_hold", S_BUSY, 17, 8'd1);
    expect_at("sw_idle", S_BUSY, 18, 8'd0);
    expect_at("sw_post", S_RST,  22, 8'd0);
    tick(1);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    bus_a.CAUSE_CLR = 1'b0;
`endif
    tick(2);
    bus_a.SYSRESETREQ = 1'b0;
    tick(3);
    bus_a.SYSRESETREQ = 1'b1;
    tick(2);
    bus_a.SYSRESETREQ = 1'b0;
    tick(1);
    bus_a.SYSRESETREQ_EN = 1'b0;
    tick(16);

    // SYSRESETREQ with enable low is ignored
    bus_a.SYSRESETREQ = 1'b1;
    expect_at("swdis_rst1",  S_RST,  1, 8'd0);
    expect_at("swdis_rst3",  S_RST,  3, 8'd0);
    expect_at("swdis_busy3", S_BUSY, 3, 8'd0);
    tick(4);
    bus_a.SYSRESETREQ = 1'b0;
    tick(2);

    // PORESETn at pulse cycle 7 aborts at once; lockup filter restarts
    bus_a.PWRUPREQ        = 2'b01;
    bus_a.LOCKUP_RESET_EN = 1'b1;
    bus_a.LOCKUP          = 1'b1;
    expect_at("por_pulse1", S_RST, 4, 8'd1);
    expect_at("por_pulse6", S_RST, 9, 8'd1);
    tick(10);
    PORESETn = 1'b0;
    expect_at("por_rst",  S_RST,  0, 8'd0);
    expect_at("por_busy", S_BUSY, 0, 8'd0);
    expect_at("por_acka", S_ACKA, 0, 8'd0);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    expect_at("por_cause", S_CAUSE, 0, 8'd0);
`endif
    #1;
    n_tests++;
    if (bus_a.SYSRST_OUT !== 1'b0) begin
      n_fail++;
      $error("FAIL por_direct_rst: observed %b expected 0", bus_a.SYSRST_OUT);
    end
    n_tests++;
    if (bus_a.RST_BUSY !== 1'b0) begin
      n_fail++;
      $error("FAIL por_direct_busy: observed %b expected 0", bus_a.RST_BUSY);
    end
    n_tests++;
    if (bus_a.PWRUPACK !== 2'b00) begin
      n_fail++;
      $error("FAIL por_direct_acka: observed %b expected 00", bus_a.PWRUPACK);
    end
    tick(2);
    PORESETn = 1'b1;
    expect_at("por_lk_pre",  S_RST,  3, 8'd0);
    expect_at("por_lk_rise", S_RST,  4, 8'd1);
    expect_at("por_lk_busy", S_BUSY, 4, 8'd1);
    expect_at("por_ack_m1",  S_ACKA, 1, 8'd0);
    expect_at("por_ack",     S_ACKA, 2, 8'd1);
`ifdef SYS_CTRL_GEN2_CAUSE_EN
    expect_at("por_cause_lk", S_CAUSE, 4, 8'd1);
`endif
    tick(24);
    bus_a.LOCKUP = 1'b0;
    tick(5);

    if (n_fail != 0)
      $display("FAIL summary: observed %0d failures, expected 0", n_fail);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
